// File: rtl/llc_set_table_ctrl.sv
// llc_set_table_ctrl
// Tracks which LLC sets are in flight between the input arbiter and the update
// stage. A request whose set is already in flight is stalled (set-conflict
// hazard). Every accepted request is given a free table slot. Its pointer
// travels down the pipeline and is handed back on remove_set_from_table.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   alloc_valid/alloc_set    upstream request and its set index
//   alloc_ready/alloc_ptr    request may issue now / slot it will occupy
//   conflict                 alloc_set matches a valid slot (registered state only)
//   remove_set_from_table    update stage retires slot table_pointer_to_remove
//   drain_req/drained        block new issues / table is empty while draining
//   full, empty, count       occupancy
//   err_remove_invalid       sticky: a remove targeted an invalid slot

`ifndef LLC_SET_BITS
`define LLC_SET_BITS 11
`endif

module llc_set_table_ctrl #(
  parameter int unsigned ENTRIES  = 8,
  parameter int unsigned PTR_BITS = $clog2(ENTRIES),
  parameter int unsigned SET_BITS = `LLC_SET_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  input  logic [SET_BITS-1:0] alloc_set,
  output logic                alloc_ready,
  output logic [PTR_BITS-1:0] alloc_ptr,
  output logic                conflict,
  input  logic                remove_set_from_table,
  input  logic [PTR_BITS-1:0] table_pointer_to_remove,
  input  logic                drain_req,
  output logic                drained,
  output logic                full,
  output logic                empty,
  output logic [PTR_BITS:0]   count,
  output logic                err_remove_invalid
);

  localparam int unsigned CNT_W = PTR_BITS + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [SET_BITS-1:0] set_q [ENTRIES];
  logic [SET_BITS-1:0] set_d [ENTRIES];
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;

  logic fire;
  logic rem_ok;
  logic rem_bad;

  // Set-match against registered slots; a same-cycle remove cannot clear it.
  always_comb begin
    conflict = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (set_q[i] == alloc_set)) conflict = 1'b1;
    end
  end

  // Lowest-index free slot; value is irrelevant when the table is full.
  always_comb begin
    alloc_ptr = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_ptr = PTR_BITS'(i);
    end
  end

  // Occupancy flags come straight from the registered counter.
  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    count = count_q;
    err_remove_invalid = err_q;
    drained = drain_req && empty;
    // Held low while in reset so nothing issues against a clearing table.
    alloc_ready = rst && !full && !conflict && !drain_req;
  end

  // Next-state: retire first, then allocate; they never hit the same slot.
  always_comb begin
    valid_d = valid_q;
    set_d   = set_q;
    count_d = count_q;
    err_d   = err_q;

    fire    = alloc_valid && alloc_ready;
    rem_ok  = remove_set_from_table && valid_q[table_pointer_to_remove];
    rem_bad = remove_set_from_table && !valid_q[table_pointer_to_remove];

    if (rem_ok) valid_d[table_pointer_to_remove] = 1'b0;
    if (rem_bad) err_d = 1'b1;

    if (fire) begin
      valid_d[alloc_ptr] = 1'b1;
      set_d[alloc_ptr]   = alloc_set;
    end

    unique case ({fire, rem_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < ENTRIES; i++) set_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < ENTRIES; i++) set_q[i] <= set_d[i];
    end
  end

endmodule

// File: tb/tb_llc_set_table_ctrl.sv
module tb_llc_set_table_ctrl;

  localparam int ENTRIES  = 8;
  localparam int PTR_BITS = 3;
  localparam int SET_BITS = 11;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                alloc_valid = 1'b0;
  logic [SET_BITS-1:0] alloc_set = '0;
  logic                alloc_ready;
  logic [PTR_BITS-1:0] alloc_ptr;
  logic                conflict;
  logic                remove_set_from_table = 1'b0;
  logic [PTR_BITS-1:0] table_pointer_to_remove = '0;
  logic                drain_req = 1'b0;
  logic                drained;
  logic                full;
  logic                empty;
  logic [PTR_BITS:0]   count;
  logic                err_remove_invalid;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a plain occupancy table.
  bit                m_valid [ENTRIES];
  bit [SET_BITS-1:0] m_set   [ENTRIES];
  bit                m_err;

  llc_set_table_ctrl dut (
    .clk                     (clk),
    .rst                     (rst),
    .alloc_valid             (alloc_valid),
    .alloc_set               (alloc_set),
    .alloc_ready             (alloc_ready),
    .alloc_ptr               (alloc_ptr),
    .conflict                (conflict),
    .remove_set_from_table   (remove_set_from_table),
    .table_pointer_to_remove (table_pointer_to_remove),
    .drain_req               (drain_req),
    .drained                 (drained),
    .full                    (full),
    .empty                   (empty),
    .count                   (count),
    .err_remove_invalid      (err_remove_invalid)
  );

  always #5 clk = ~clk;

  function automatic int m_count();
    int n = 0;
    foreach (m_valid[i]) n += int'(m_valid[i]);
    return n;
  endfunction

  function automatic bit m_conflict(bit [SET_BITS-1:0] s);
    foreach (m_valid[i]) if (m_valid[i] && m_set[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_free();
    foreach (m_valid[i]) if (!m_valid[i]) return i;
    return 0;
  endfunction

  function automatic bit m_ready();
    return rst && (m_count() < ENTRIES) && !m_conflict(alloc_set) && !drain_req;
  endfunction

  // One clock: apply the rules to the model at the edge, then settle.
  task automatic tick();
    int p;
    bit f;
    p = m_free();
    f = alloc_valid && m_ready();
    @(posedge clk);
    if (rst) begin
      if (remove_set_from_table) begin
        if (m_valid[table_pointer_to_remove]) m_valid[table_pointer_to_remove] = 1'b0;
        else m_err = 1'b1;
      end
      if (f) begin
        m_valid[p] = 1'b1;
        m_set[p]   = alloc_set;
      end
    end
    #1;
  endtask

  task automatic model_clear();
    foreach (m_valid[i]) begin
      m_valid[i] = 1'b0;
      m_set[i]   = '0;
    end
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    alloc_valid = 1'b0;
    remove_set_from_table = 1'b0;
    drain_req = 1'b0;
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic alloc_n(int n, int base);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1'b1;
      alloc_set = SET_BITS'(base + i);
      tick();
    end
    alloc_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_clear();
    alloc_valid = 1'b1;
    alloc_set = 11'h012;
    drain_req = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d exp 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b exp 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b exp 0", full); end
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b exp 0", alloc_ready); end
    n_cmp++; if (drained !== 1'b1) begin n_bad++; $display("FAIL reset_drained_hi: got %b exp 1", drained); end
    drain_req = 1'b0;
    #1;
    n_cmp++; if (drained !== 1'b0) begin n_bad++; $display("FAIL reset_drained_lo: got %b exp 0", drained); end
    n_cmp++; if (err_remove_invalid !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b exp 0", err_remove_invalid); end
    do_reset();
  endtask

  task automatic test_first_alloc();
    do_reset();
    alloc_valid = 1'b1;
    alloc_set = 11'h012;
    #1;
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL first_ready: got %b exp 1", alloc_ready); end
    n_cmp++; if (alloc_ptr !== 3'd0) begin n_bad++; $display("FAIL first_ptr: got %0d exp 0", alloc_ptr); end
    tick();
    alloc_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL first_count: got %0d exp 1", count); end
    n_cmp++; if (conflict !== 1'b1) begin n_bad++; $display("FAIL first_conflict: got %b exp 1", conflict); end
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL first_ready_blocked: got %b exp 0", alloc_ready); end
  endtask

  // Slot 0 holds 0x12 from the previous test.
  task automatic test_remove_conflict();
    alloc_valid = 1'b1;
    alloc_set = 11'h012;
    remove_set_from_table = 1'b1;
    table_pointer_to_remove = 3'd0;
    #1;
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL rmconf_ready_same: got %b exp 0", alloc_ready); end
    n_cmp++; if (conflict !== 1'b1) begin n_bad++; $display("FAIL rmconf_conflict_same: got %b exp 1", conflict); end
    tick();
    remove_set_from_table = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL rmconf_count: got %0d exp 0", count); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL rmconf_ready_next: got %b exp 1", alloc_ready); end
    n_cmp++; if (alloc_ptr !== 3'd0) begin n_bad++; $display("FAIL rmconf_ptr: got %0d exp 0", alloc_ptr); end
    tick();
    alloc_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL rmconf_refire: got %0d exp 1", count); end
  endtask

  task automatic test_full();
    do_reset();
    alloc_n(8, 'h40);
    alloc_valid = 1'b1;
    alloc_set = 11'h7ff;
    #1;
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_flag: got %b exp 1", full); end
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_count: got %0d exp 8", count); end
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b exp 0", alloc_ready); end
    remove_set_from_table = 1'b1;
    table_pointer_to_remove = 3'd5;
    #1;
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_rm: got %b exp 0", alloc_ready); end
    tick();
    remove_set_from_table = 1'b0;
    #1;
    n_cmp++; if (alloc_ptr !== 3'd5) begin n_bad++; $display("FAIL full_ptr5: got %0d exp 5", alloc_ptr); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_after: got %b exp 1", alloc_ready); end
    tick();
    alloc_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_refill: got %0d exp 8", count); end
  endtask

  task automatic test_fire_remove();
    do_reset();
    alloc_n(5, 'h20);
    remove_set_from_table = 1'b1;
    table_pointer_to_remove = 3'd3;
    tick();
    alloc_valid = 1'b1;
    alloc_set = 11'h055;
    table_pointer_to_remove = 3'd1;
    #1;
    n_cmp++; if (alloc_ptr !== 3'd3) begin n_bad++; $display("FAIL fr_ptr: got %0d exp 3", alloc_ptr); end
    n_cmp++; if (count !== 4'd4) begin n_bad++; $display("FAIL fr_count_before: got %0d exp 4", count); end
    tick();
    alloc_valid = 1'b0;
    remove_set_from_table = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd4) begin n_bad++; $display("FAIL fr_count_after: got %0d exp 4", count); end
    n_cmp++; if (conflict !== 1'b1) begin n_bad++; $display("FAIL fr_slot3_valid: got %b exp 1", conflict); end
    alloc_set = 11'h021;
    #1;
    n_cmp++; if (conflict !== 1'b0) begin n_bad++; $display("FAIL fr_slot1_cleared: got %b exp 0", conflict); end
    n_cmp++; if (alloc_ptr !== 3'd1) begin n_bad++; $display("FAIL fr_free_ptr: got %0d exp 1", alloc_ptr); end
  endtask

  // Slots 0,2,3,4 valid from the previous test; slot 6 is free.
  task automatic test_remove_invalid();
    remove_set_from_table = 1'b1;
    table_pointer_to_remove = 3'd6;
    tick();
    remove_set_from_table = 1'b0;
    #1;
    n_cmp++; if (err_remove_invalid !== 1'b1) begin n_bad++; $display("FAIL rminv_err: got %b exp 1", err_remove_invalid); end
    n_cmp++; if (count !== 4'd4) begin n_bad++; $display("FAIL rminv_count: got %0d exp 4", count); end
    repeat (3) tick();
    n_cmp++; if (err_remove_invalid !== 1'b1) begin n_bad++; $display("FAIL rminv_sticky: got %b exp 1", err_remove_invalid); end
  endtask

  task automatic test_drain();
    do_reset();
    alloc_n(2, 'h30);
    drain_req = 1'b1;
    alloc_valid = 1'b1;
    alloc_set = 11'h099;
    #1;
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL drain_ready: got %b exp 0", alloc_ready); end
    n_cmp++; if (drained !== 1'b0) begin n_bad++; $display("FAIL drain_busy: got %b exp 0", drained); end
    remove_set_from_table = 1'b1;
    table_pointer_to_remove = 3'd0;
    tick();
    n_cmp++; if (drained !== 1'b0) begin n_bad++; $display("FAIL drain_one_left: got %b exp 0", drained); end
    table_pointer_to_remove = 3'd1;
    tick();
    remove_set_from_table = 1'b0;
    #1;
    n_cmp++; if (drained !== 1'b1) begin n_bad++; $display("FAIL drain_done: got %b exp 1", drained); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL drain_count: got %0d exp 0", count); end
    tick();
    n_cmp++; if (drained !== 1'b1) begin n_bad++; $display("FAIL drain_hold: got %b exp 1", drained); end
    // Refill, then reset in the middle of a drain.
    drain_req = 1'b0;
    alloc_n(2, 'h30);
    drain_req = 1'b1;
    #1;
    n_cmp++; if (drained !== 1'b0) begin n_bad++; $display("FAIL drain2_busy: got %b exp 0", drained); end
    rst = 1'b0;
    model_clear();
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL drain_rst_empty: got %b exp 1", empty); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL drain_rst_count: got %0d exp 0", count); end
    n_cmp++; if (drained !== 1'b1) begin n_bad++; $display("FAIL drain_rst_drained: got %b exp 1", drained); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    drain_req = 1'b0;
    alloc_set = 11'h030;
    #1;
    n_cmp++; if (conflict !== 1'b0) begin n_bad++; $display("FAIL drain_rst_slots: got %b exp 0", conflict); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL drain_rst_ready: got %b exp 1", alloc_ready); end
  endtask

  task automatic test_random();
    int vq[$];
    int cnt;
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      alloc_valid = ($urandom_range(0, 3) != 0);
      alloc_set = SET_BITS'($urandom_range(0, 11));
      if (($urandom_range(0, 19)) == 0) drain_req = ~drain_req;
      vq.delete();
      foreach (m_valid[i]) if (m_valid[i]) vq.push_back(i);
      remove_set_from_table = ($urandom_range(0, 2) == 0);
      if (vq.size() > 0 && $urandom_range(0, 9) != 0)
        table_pointer_to_remove = PTR_BITS'(vq[$urandom_range(0, vq.size() - 1)]);
      else
        table_pointer_to_remove = PTR_BITS'($urandom_range(0, ENTRIES - 1));
      #1;
      cnt = m_count();
      n_cmp++; if (conflict !== m_conflict(alloc_set)) begin n_bad++; $display("FAIL rnd_conflict cyc %0d: got %b exp %b", cyc, conflict, m_conflict(alloc_set)); end
      n_cmp++; if (alloc_ready !== m_ready()) begin n_bad++; $display("FAIL rnd_ready cyc %0d: got %b exp %b", cyc, alloc_ready, m_ready()); end
      if (cnt < ENTRIES) begin
        n_cmp++; if (alloc_ptr !== PTR_BITS'(m_free())) begin n_bad++; $display("FAIL rnd_ptr cyc %0d: got %0d exp %0d", cyc, alloc_ptr, m_free()); end
      end
      n_cmp++; if (count !== (PTR_BITS+1)'(cnt)) begin n_bad++; $display("FAIL rnd_count cyc %0d: got %0d exp %0d", cyc, count, cnt); end
      n_cmp++; if (full !== (cnt == ENTRIES)) begin n_bad++; $display("FAIL rnd_full cyc %0d: got %b", cyc, full); end
      n_cmp++; if (empty !== (cnt == 0)) begin n_bad++; $display("FAIL rnd_empty cyc %0d: got %b", cyc, empty); end
      n_cmp++; if (drained !== (drain_req && cnt == 0)) begin n_bad++; $display("FAIL rnd_drained cyc %0d: got %b", cyc, drained); end
      n_cmp++; if (err_remove_invalid !== m_err) begin n_bad++; $display("FAIL rnd_err cyc %0d: got %b exp %b", cyc, err_remove_invalid, m_err); end
      tick();
    end
    alloc_valid = 1'b0;
    remove_set_from_table = 1'b0;
    drain_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_alloc();
    test_remove_conflict();
    test_full();
    test_fire_remove();
    test_remove_invalid();
    test_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
